// File: rtl/e203_exu_longp_wbarb_pkg.sv
// Shared widths and FSM encoding for the long-pipe writeback arbiter.
package e203_exu_longp_wbarb_pkg;

  localparam int E203_XLEN        = 32;
  localparam int E203_ITAG_WIDTH  = 1;
  localparam int E203_RFIDX_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    EXC  = 2'd2
  } wbarb_state_e;

endpackage

// File: rtl/e203_exu_longp_wbarb_sel.sv
// Itag match against the OITF retire pointer with fixed lowest-index priority select.
module e203_exu_longp_wbarb_sel #(
  parameter int N_SRC  = 2,
  parameter int ITAG_W = 1,
  parameter int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*ITAG_W-1:0] src_itag,
  input  logic [ITAG_W-1:0]       ret_ptr,
  input  logic                    oitf_empty,
  output logic [N_SRC-1:0]        sel_oh,
  output logic [SEL_W-1:0]        sel_idx,
  output logic                    any_match
);

  logic [N_SRC-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < N_SRC; i++) begin
      match[i] = src_valid[i] && (src_itag[i*ITAG_W +: ITAG_W] == ret_ptr) && !oitf_empty;
    end
  end

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_idx   = SEL_W'(i);
      end
    end
  end

  assign any_match = |match;

endmodule

// File: rtl/e203_exu_longp_wbarb.sv
// In-order long-pipe writeback arbiter: retires only the completion whose itag is the OITF head.
// Optional watchdog enabled by defining E203_LONGP_WBARB_TIMEOUT_EN.
module e203_exu_longp_wbarb
  import e203_exu_longp_wbarb_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int XLEN        = E203_XLEN,
  parameter int ITAG_W      = E203_ITAG_WIDTH,
  parameter int RFIDX_W     = E203_RFIDX_WIDTH,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*ITAG_W-1:0] src_itag,
  input  logic [N_SRC*XLEN-1:0]   src_wdat,
  input  logic [N_SRC-1:0]        src_err,
  input  logic                    oitf_empty,
  input  logic [ITAG_W-1:0]       oitf_ret_ptr,
  input  logic                    oitf_ret_rdwen,
  input  logic [RFIDX_W-1:0]      oitf_ret_rdidx,
  output logic                    oitf_ret_ena,
  output logic                    wbck_o_valid,
  input  logic                    wbck_o_ready,
  output logic [XLEN-1:0]         wbck_o_wdat,
  output logic [RFIDX_W-1:0]      wbck_o_rdidx,
  output logic                    excp_o_valid,
  input  logic                    excp_o_ready,
  output logic [ITAG_W-1:0]       excp_o_itag,
  output logic                    hang_err
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  wbarb_state_e     state_q, state_d, acc_next;
  logic [N_SRC-1:0] sel_oh;
  logic [SEL_W-1:0] sel_idx;
  logic             any_match, acc, sel_err;
  logic [XLEN-1:0]  sel_wdat;
  logic [ITAG_W-1:0] sel_itag;

  e203_exu_longp_wbarb_sel #(
    .N_SRC (N_SRC),
    .ITAG_W(ITAG_W),
    .SEL_W (SEL_W)
  ) u_sel (
    .src_valid (src_valid),
    .src_itag  (src_itag),
    .ret_ptr   (oitf_ret_ptr),
    .oitf_empty(oitf_empty),
    .sel_oh    (sel_oh),
    .sel_idx   (sel_idx),
    .any_match (any_match)
  );

  assign sel_err  = src_err[sel_idx];
  assign sel_wdat = src_wdat[sel_idx*XLEN +: XLEN];
  assign sel_itag = src_itag[sel_idx*ITAG_W +: ITAG_W];

  // A new result may enter only when the output slot is empty or draining this cycle.
  assign acc          = any_match && ((state_q == IDLE) || ((state_q == WB) && wbck_o_ready));
  assign src_ready    = acc ? sel_oh : '0;
  assign oitf_ret_ena = acc;
  assign acc_next     = sel_err ? EXC : (oitf_ret_rdwen ? WB : IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = acc_next;
      WB:      if (wbck_o_ready) state_d = acc ? acc_next : IDLE;
      EXC:     if (excp_o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wbck_o_valid = (state_q == WB);
    excp_o_valid = (state_q == EXC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbck_o_wdat  <= '0;
      wbck_o_rdidx <= '0;
      excp_o_itag  <= '0;
    end else if (acc) begin
      if (sel_err) begin
        excp_o_itag <= sel_itag;
      end else if (oitf_ret_rdwen) begin
        wbck_o_wdat  <= sel_wdat;
        wbck_o_rdidx <= oitf_ret_rdidx;
      end
    end
  end

`ifdef E203_LONGP_WBARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             hang_q;

  // Counts cycles the OITF head sits unretired; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      hang_q   <= 1'b0;
    end else begin
      if (oitf_empty || oitf_ret_ena) wdog_cnt <= '0;
      else if (wdog_cnt != CNT_W'(TIMEOUT_CYC)) wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt == CNT_W'(TIMEOUT_CYC)) hang_q <= 1'b1;
    end
  end

  assign hang_err = hang_q;
`else
  assign hang_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_e203_exu_longp_wbarb.sv
// Directed plus randomized bench for e203_exu_longp_wbarb against an output-slot/OITF-queue model.
module tb_e203_exu_longp_wbarb;

  localparam int N  = 2;
  localparam int XL = 32;
  localparam int IW = 1;
  localparam int RW = 5;
  localparam int TO = 8;

  typedef struct {
    bit          is_exc;
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        itag;
  } pend_t;

  typedef struct {
    bit          rdwen;
    logic [4:0]  rdidx;
  } oitf_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    src_valid, src_ready, src_err;
  logic [N*IW-1:0] src_itag;
  logic [N*XL-1:0] src_wdat;
  logic            oitf_empty, oitf_ret_rdwen, oitf_ret_ena;
  logic [IW-1:0]   oitf_ret_ptr;
  logic [RW-1:0]   oitf_ret_rdidx;
  logic            wbck_o_valid, wbck_o_ready, excp_o_valid, excp_o_ready, hang_err;
  logic [XL-1:0]   wbck_o_wdat;
  logic [RW-1:0]   wbck_o_rdidx;
  logic [IW-1:0]   excp_o_itag;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic exp_hang;

  pend_t pend_q[$];
  oitf_t oitf_q[$];

  e203_exu_longp_wbarb #(
    .N_SRC(N), .XLEN(XL), .ITAG_W(IW), .RFIDX_W(RW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_itag(src_itag),
    .src_wdat(src_wdat), .src_err(src_err),
    .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr),
    .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdidx(oitf_ret_rdidx),
    .oitf_ret_ena(oitf_ret_ena),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready),
    .wbck_o_wdat(wbck_o_wdat), .wbck_o_rdidx(wbck_o_rdidx),
    .excp_o_valid(excp_o_valid), .excp_o_ready(excp_o_ready),
    .excp_o_itag(excp_o_itag), .hang_err(hang_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] vld, input logic [N*IW-1:0] itag,
                               input logic [N*XL-1:0] wdat, input logic [N-1:0] err);
    src_valid = vld;
    src_itag  = itag;
    src_wdat  = wdat;
    src_err   = err;
  endtask

  initial begin
`ifdef E203_LONGP_WBARB_TIMEOUT_EN
    exp_hang = 1'b1;
`else
    exp_hang = 1'b0;
`endif
    rst = 1'b1;
    applyStimulus('0, '0, '0, '0);
    oitf_empty = 1'b1; oitf_ret_ptr = '0; oitf_ret_rdwen = 1'b0; oitf_ret_rdidx = '0;
    wbck_o_ready = 1'b0; excp_o_ready = 1'b0;
    tick(); tick();
    #3;
    checkOutput("rst_wbck_valid", 64'(wbck_o_valid), 64'(0));
    checkOutput("rst_excp_valid", 64'(excp_o_valid), 64'(0));
    checkOutput("rst_hang",       64'(hang_err),     64'(0));
    checkOutput("rst_wdat",       64'(wbck_o_wdat),  64'(0));
    checkOutput("rst_rdidx",      64'(wbck_o_rdidx), 64'(0));
    checkOutput("rst_excp_itag",  64'(excp_o_itag),  64'(0));
    rst = 1'b0;
    tick();

    // Unit 1 retires the head into the regfile.
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; oitf_ret_rdwen = 1'b1; oitf_ret_rdidx = 5'd5;
    applyStimulus(2'b10, 2'b00, {32'hDEADBEEF, 32'h0}, 2'b00);
    #3;
    checkOutput("d1_src_ready", 64'(src_ready),    64'(2'b10));
    checkOutput("d1_ret_ena",   64'(oitf_ret_ena), 64'(1));
    tick();
    applyStimulus('0, '0, '0, '0);
    oitf_empty = 1'b1; oitf_ret_ptr = 1'b1;
    #3;
    checkOutput("d1_wbck_valid", 64'(wbck_o_valid), 64'(1));
    checkOutput("d1_wdat",       64'(wbck_o_wdat),  64'(32'hDEADBEEF));
    checkOutput("d1_rdidx",      64'(wbck_o_rdidx), 64'(5));
    checkOutput("d1_excp_valid", 64'(excp_o_valid), 64'(0));
    wbck_o_ready = 1'b1;
    tick();

    // Wrong itag is held off until the pointer catches up.
    wbck_o_ready = 1'b0;
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; oitf_ret_rdidx = 5'd7;
    applyStimulus(2'b01, 2'b01, {32'h0, 32'h1234}, 2'b00);
    for (int k = 0; k < 10; k++) begin
      #3;
      checkOutput("d2_stall_ready", 64'(src_ready),    64'(0));
      checkOutput("d2_stall_ena",   64'(oitf_ret_ena), 64'(0));
      tick();
    end
    #3;
    checkOutput("d2_hang", 64'(hang_err), 64'(exp_hang));
    oitf_ret_ptr = 1'b1;
    #1;
    checkOutput("d2_ready", 64'(src_ready),    64'(2'b01));
    checkOutput("d2_ena",   64'(oitf_ret_ena), 64'(1));
    tick();
    applyStimulus('0, '0, '0, '0);
    oitf_empty = 1'b1;
    #3;
    checkOutput("d2_wbck_valid", 64'(wbck_o_valid), 64'(1));
    checkOutput("d2_wdat",       64'(wbck_o_wdat),  64'(32'h1234));
    checkOutput("d2_rdidx",      64'(wbck_o_rdidx), 64'(7));

    // Back-to-back acceptance while the previous result drains.
    wbck_o_ready = 1'b1;
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; oitf_ret_rdidx = 5'd3;
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h1}, 2'b00);
    #1;
    checkOutput("d3_ready", 64'(src_ready),    64'(2'b01));
    checkOutput("d3_ena",   64'(oitf_ret_ena), 64'(1));
    tick();

    // Draining again, an excepting completion from unit 1 enters.
    oitf_ret_ptr = 1'b1;
    applyStimulus(2'b10, 2'b10, {32'h55, 32'h0}, 2'b10);
    #3;
    checkOutput("d3_wbck_valid", 64'(wbck_o_valid), 64'(1));
    checkOutput("d3_wdat",       64'(wbck_o_wdat),  64'(1));
    checkOutput("d3_rdidx",      64'(wbck_o_rdidx), 64'(3));
    checkOutput("d4_ready",      64'(src_ready),    64'(2'b10));
    checkOutput("d4_ena",        64'(oitf_ret_ena), 64'(1));
    tick();

    wbck_o_ready = 1'b0;
    oitf_ret_ptr = 1'b0; oitf_ret_rdwen = 1'b0;
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h77}, 2'b00);
    for (int k = 0; k < 5; k++) begin
      #3;
      checkOutput("d4_excp_valid", 64'(excp_o_valid), 64'(1));
      checkOutput("d4_excp_itag",  64'(excp_o_itag),  64'(1));
      checkOutput("d4_wbck_valid", 64'(wbck_o_valid), 64'(0));
      checkOutput("d4_hold_ready", 64'(src_ready),    64'(0));
      checkOutput("d4_hold_ena",   64'(oitf_ret_ena), 64'(0));
      tick();
    end
    excp_o_ready = 1'b1;
    #3;
    checkOutput("d4_exc_noacc", 64'(src_ready), 64'(0));
    tick();

    // Match with rdwen=0 pops the OITF without a writeback.
    excp_o_ready = 1'b0;
    #3;
    checkOutput("d5_excp_valid", 64'(excp_o_valid), 64'(0));
    checkOutput("d5_ready",      64'(src_ready),    64'(2'b01));
    checkOutput("d5_ena",        64'(oitf_ret_ena), 64'(1));
    tick();
    applyStimulus('0, '0, '0, '0);
    #3;
    checkOutput("d5_wbck_valid", 64'(wbck_o_valid), 64'(0));
    checkOutput("d5_excp_idle",  64'(excp_o_valid), 64'(0));
    checkOutput("d5_hang_sticky", 64'(hang_err), 64'(exp_hang));

    // Reset while a writeback is pending drops it.
    oitf_ret_ptr = 1'b0; oitf_ret_rdwen = 1'b1; oitf_ret_rdidx = 5'd9;
    applyStimulus(2'b01, 2'b00, {32'h0, 32'hAA}, 2'b00);
    tick();
    applyStimulus('0, '0, '0, '0);
    oitf_empty = 1'b1;
    #3;
    checkOutput("d6_wbck_valid", 64'(wbck_o_valid), 64'(1));
    rst = 1'b1;
    tick();
    #3;
    checkOutput("d6_rst_wbck_valid", 64'(wbck_o_valid), 64'(0));
    checkOutput("d6_rst_wdat",       64'(wbck_o_wdat),  64'(0));
    checkOutput("d6_rst_rdidx",      64'(wbck_o_rdidx), 64'(0));
    checkOutput("d6_rst_excp",       64'(excp_o_valid), 64'(0));
    checkOutput("d6_rst_hang",       64'(hang_err),     64'(0));
    rst = 1'b0;
    tick();

    // Randomized traffic against the slot/queue model.
    begin
      int retired = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        int m, exp_sel;
        bit allowed, acc;
        logic [N-1:0] exp_ready;
        logic ptr;
        if (oitf_q.size() < 2 && $urandom_range(0, 2) != 0) begin
          oitf_t e;
          e.rdwen = ($urandom_range(0, 3) != 0);
          e.rdidx = 5'($urandom_range(0, 31));
          oitf_q.push_back(e);
        end
        ptr = retired[0];
        oitf_empty   = (oitf_q.size() == 0);
        oitf_ret_ptr = ptr;
        if (oitf_q.size() != 0) begin
          oitf_ret_rdwen = oitf_q[0].rdwen;
          oitf_ret_rdidx = oitf_q[0].rdidx;
        end else begin
          oitf_ret_rdwen = 1'($urandom_range(0, 1));
          oitf_ret_rdidx = 5'($urandom_range(0, 31));
        end
        m = $urandom_range(0, N);
        for (int i = 0; i < N; i++) begin
          if (i == m) begin
            src_valid[i] = 1'b1;
            src_itag[i*IW +: IW] = ptr;
          end else begin
            src_valid[i] = 1'($urandom_range(0, 1));
            src_itag[i*IW +: IW] = ~ptr;
          end
          src_err[i] = ($urandom_range(0, 5) == 0);
          src_wdat[i*XL +: XL] = $urandom;
        end
        wbck_o_ready = 1'($urandom_range(0, 1));
        excp_o_ready = 1'($urandom_range(0, 1));
        #3;
        exp_sel = -1;
        for (int i = 0; i < N; i++)
          if (exp_sel < 0 && src_valid[i] && src_itag[i*IW +: IW] == ptr && oitf_q.size() != 0)
            exp_sel = i;
        allowed   = (pend_q.size() == 0) || (!pend_q[0].is_exc && wbck_o_ready);
        acc       = (exp_sel >= 0) && allowed;
        exp_ready = acc ? N'(1 << exp_sel) : '0;
        checkOutput("r_src_ready", 64'(src_ready),    64'(exp_ready));
        checkOutput("r_ret_ena",   64'(oitf_ret_ena), 64'(acc));
        checkOutput("r_wbck_valid", 64'(wbck_o_valid), 64'(pend_q.size() != 0 && !pend_q[0].is_exc));
        checkOutput("r_excp_valid", 64'(excp_o_valid), 64'(pend_q.size() != 0 && pend_q[0].is_exc));
        if (pend_q.size() != 0) begin
          if (pend_q[0].is_exc) begin
            checkOutput("r_excp_itag", 64'(excp_o_itag), 64'(pend_q[0].itag));
          end else begin
            checkOutput("r_wdat",  64'(wbck_o_wdat),  64'(pend_q[0].wdat));
            checkOutput("r_rdidx", 64'(wbck_o_rdidx), 64'(pend_q[0].rdidx));
          end
        end
        if (pend_q.size() != 0 &&
            ((!pend_q[0].is_exc && wbck_o_ready) || (pend_q[0].is_exc && excp_o_ready)))
          void'(pend_q.pop_front());
        if (acc) begin
          pend_t p;
          p.is_exc = src_err[exp_sel];
          p.wdat   = src_wdat[exp_sel*XL +: XL];
          p.rdidx  = oitf_q[0].rdidx;
          p.itag   = ptr;
          if (p.is_exc || oitf_q[0].rdwen) pend_q.push_back(p);
          void'(oitf_q.pop_front());
          retired++;
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/e203_exu_longp_wbarb.md
Name: e203_exu_longp_wbarb

Overview:
In-order writeback arbiter for long-pipe units such as LSU, shared MULDIV and NICE. Each unit returns a completion tagged with the itag it was given at dispatch. The block accepts only the completion whose itag equals the OITF retire pointer, then pops the OITF entry. It drives one registered writeback port to the regfile and one registered exception port to commit.
It sits between the long-pipe units and the OITF/regfile write port, downstream of dispatch.

Parameters:
N_SRC, 2, number of long-pipe requesters
XLEN, 32, data width
ITAG_W, 1, itag width (OITF depth = 2**ITAG_W)
RFIDX_W, 5, register index width
TIMEOUT_CYC, 1024, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_valid  in  N_SRC  completion valid per unit
src_ready  out  N_SRC  completion accepted
src_itag  in  N_SRC*ITAG_W  packed itag, unit i at [i*ITAG_W +: ITAG_W]
src_wdat  in  N_SRC*XLEN  packed result data
src_err  in  N_SRC  completion carries exception
oitf_empty  in  1  OITF has no entries
oitf_ret_ptr  in  ITAG_W  OITF read (oldest) pointer
oitf_ret_rdwen  in  1  oldest entry writes rd
oitf_ret_rdidx  in  RFIDX_W  oldest entry rd index
oitf_ret_ena  out  1  pop oldest OITF entry
wbck_o_valid  out  1  regfile write request
wbck_o_ready  in  1  regfile write accepted
wbck_o_wdat  out  XLEN  write data
wbck_o_rdidx  out  RFIDX_W  write index
excp_o_valid  out  1  long-pipe exception to commit
excp_o_ready  in  1  commit accepted exception
excp_o_itag  out  ITAG_W  itag of excepting instr
hang_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE. wbck_o_valid, excp_o_valid, hang_err, wbck_o_wdat, wbck_o_rdidx, excp_o_itag are all 0.
- Match rule: match[i] = src_valid[i] & (src_itag[i]==oitf_ret_ptr) & ~oitf_empty.
  - Selection is the lowest-index matching unit. More than one match is a protocol violation.
- Accept condition (acc) is any match AND one of:
  - state==IDLE, or
  - state==WB & wbck_o_ready.
- On acc, combinationally in the same cycle: src_ready[sel]=1, all other src_ready=0, oitf_ret_ena=1.
- src_ready never asserts without a match. src_valid without a match is held off (ready=0).
- States:
  - IDLE: on acc with src_err → capture itag, go EXC. On acc with ~err & oitf_ret_rdwen → capture wdat/rdidx, go WB. On acc with ~err & ~rdwen → stay IDLE; nothing written, OITF still popped.
  - WB: wbck_o_valid=1; data held stable until handshake. On wbck_o_ready: if acc in the same cycle, follow the IDLE acc rules (back-to-back, 1 result/cycle); else go IDLE.
  - EXC: excp_o_valid=1; no acceptance. On excp_o_ready → IDLE.
- Latency: 1 cycle from src handshake to wbck_o_valid/excp_o_valid. Throughput is 1/cycle for non-excepting results.
- wbck_o_valid and excp_o_valid are never high together.
- oitf_ret_ptr wraps modulo 2**ITAG_W; the block compares only and keeps no pointer state.
- Reset mid-operation: a pending WB/EXC is dropped and the state returns to IDLE.

Optional Feature:
E203_LONGP_WBARB_TIMEOUT_EN
- Defined: a counter of width $clog2(TIMEOUT_CYC+1) increments each cycle with ~oitf_empty & ~oitf_ret_ena, and clears on oitf_ret_ena or oitf_empty.
  - When it reaches TIMEOUT_CYC, hang_err sets and stays set until rst. The counter saturates.
- Undefined: no counter; hang_err is tied 0.

Decomposition:
- Shared package/defines: state encoding (IDLE=2'd0, WB=2'd1, EXC=2'd2), and width macros from e203_defines (E203_XLEN, E203_ITAG_WIDTH, E203_RFIDX_WIDTH) feeding the parameter defaults.
- One sub-module: e203_exu_longp_wbarb_sel — combinational itag-match plus fixed-priority one-hot select and index encode.
- FSM, data registers and watchdog live in the top.

Test Plan:
- Unit 1 valid with itag=0, ret_ptr=0, rdwen=1, rdidx=5, wdat=0xDEADBEEF → same cycle: src_ready=2'b10, oitf_ret_ena=1. Next cycle: wbck_o_valid=1, rdidx=5, wdat=0xDEADBEEF.
- Unit 0 itag=1 while ret_ptr=0, oitf non-empty → src_ready=0 and oitf_ret_ena=0 for 10 cycles. After ret_ptr changes to 1 → accepted same cycle.
- Back-to-back: WB holding and wbck_o_ready=1, unit 0 matches with wdat=0x1 → accepted same cycle. Next cycle wbck_o_wdat=0x1, valid stays high, no bubble.
- src_err=1 on the matching unit, itag=1 → EXC with excp_o_itag=1, wbck_o_valid=0. No acceptance while excp_o_ready=0 for 5 cycles. excp_o_ready=1 → IDLE.
- Match with rdwen=0 → oitf_ret_ena=1, wbck_o_valid stays 0.
- With TIMEOUT_EN and TIMEOUT_CYC=8: OITF non-empty, no retire for 8 cycles → hang_err=1, stays 1 until rst. Assert rst while in WB → next cycle all outputs 0, state IDLE.
